// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states and the bundle of
// register-bank control lines.
package pipe_ctrl_pkg;

  localparam int ZERO_REG_DFLT = 31;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_FREEZE = '{default: 1'b0};
  localparam pipe_ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                         ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                         if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                         ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                         if_id_flush: 1'b1, id_ex_flush: 1'b1};
  // Hold PC and IF/ID, push a bubble into ID/EX, let the older stages drain.
  localparam pipe_ctrl_t CTRL_STALL  = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1,
                                         ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                         if_id_flush: 1'b0, id_ex_flush: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction reading the register a load
// in EX is about to write. The zero register never creates a dependency.
module hazard_detect #(
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rm,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  hazard
);
  localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);

  logic rn_hit, rm_hit;

  assign rn_hit = (ex_rd == id_rn);
  assign rm_hit = id_uses_rm && (ex_rd == id_rm);
  assign hazard = ex_mem_read && (ex_rd != ZR) && (rn_hit || rm_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives bank enables/clears and PC enable.
// Optional STALL_PERF_CNT_EN adds a saturating stall-cycle counter with synchronous clear.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int ZERO_REG       = ZERO_REG_DFLT,
  parameter int BRANCH_PENALTY = 2,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rm,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  input  logic                  stall_cnt_clr,
  output logic [31:0]           stall_cycles
`endif
);
  localparam int                WCW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0]    WAIT_MAX = WCW'(MEM_TIMEOUT);
  localparam logic [1:0]        BR_INIT  = 2'(BRANCH_PENALTY - 1);

  pipe_state_t    state, state_n, ret_state, ret_n, eff;
  logic [1:0]     br_cnt, br_cnt_n;
  logic [WCW-1:0] wait_cnt, wait_cnt_n;
  logic           tmo_set, hazard;
  pipe_ctrl_t     ctrl, ctrl_q;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_hd (
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rm  (id_uses_rm),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      ret_state   <= RUN;
      br_cnt      <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      ret_state <= ret_n;
      br_cnt    <= br_cnt_n;
      wait_cnt  <= wait_cnt_n;
      if (tmo_set) mem_timeout <= 1'b1;
    end
  end

  // The cycle mem_busy drops out of MEM_WAIT is decided as if already back in the saved state.
  assign eff = (state == MEM_WAIT && !mem_busy) ? ret_state : state;

  always_comb begin
    state_n    = state;
    ret_n      = ret_state;
    br_cnt_n   = br_cnt;
    wait_cnt_n = wait_cnt;
    tmo_set    = 1'b0;
    ctrl       = CTRL_FREEZE;
    if (mem_busy) begin
      state_n = MEM_WAIT;
      if (state == MEM_WAIT) begin
        if (wait_cnt == WAIT_MAX) tmo_set = 1'b1;
        else                      wait_cnt_n = wait_cnt + 1'b1;
      end else begin
        wait_cnt_n = WCW'(1);
        ret_n      = (state == BR_FLUSH) ? BR_FLUSH : RUN;
      end
    end else begin
      wait_cnt_n = '0;
      case (eff)
        BR_FLUSH: begin
          ctrl = CTRL_FLUSH;
          if (br_cnt <= 2'd1) begin
            state_n  = RUN;
            br_cnt_n = '0;
          end else begin
            state_n  = BR_FLUSH;
            br_cnt_n = br_cnt - 2'd1;
          end
        end
        default: begin
          state_n = RUN;
          if (ex_branch_taken) begin
            ctrl = CTRL_FLUSH;
            if (BRANCH_PENALTY > 1) begin
              state_n  = BR_FLUSH;
              br_cnt_n = BR_INIT;
            end
          end else if (hazard && eff == RUN) begin
            ctrl    = CTRL_STALL;
            state_n = LU_STALL;
          end else begin
            ctrl = CTRL_NORMAL;
          end
        end
      endcase
    end
  end

  assign ctrl_q      = reset ? ctrl : CTRL_FREEZE;
  assign pc_en       = ctrl_q.pc_en;
  assign if_id_en    = ctrl_q.if_id_en;
  assign id_ex_en    = ctrl_q.id_ex_en;
  assign ex_mem_en   = ctrl_q.ex_mem_en;
  assign mem_wb_en   = ctrl_q.mem_wb_en;
  assign if_id_flush = ctrl_q.if_id_flush;
  assign id_ex_flush = ctrl_q.id_ex_flush;

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      stall_cycles <= '0;
    else if (stall_cnt_clr)                          stall_cycles <= '0;
    else if (!ctrl.pc_en && stall_cycles != '1)      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, each cycle compared
// against a counter-based model of the stall/flush rules.
module tb_pipe_hazard_ctrl;
  localparam int RW = 5, ZR = 31, BP = 2, MT = 15;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_NORMAL = 7'b1111100;
  localparam logic [6:0] V_FLUSH  = 7'b1111111;
  localparam logic [6:0] V_STALL  = 7'b0011101;

  logic clk = 1'b0, reset = 1'b0;
  logic [RW-1:0] id_rn = '0, id_rm = '0, ex_rd = '0;
  logic id_uses_rm = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_timeout;
`ifdef STALL_PERF_CNT_EN
  logic stall_cnt_clr = 1'b0;
  logic [31:0] stall_cycles;
  int   m_perf, exp_perf;
`endif

  int checks = 0, errors = 0;
  // Model: flush cycles still owed, busy run length, one-shot hazard mask, sticky timeout.
  int   flush_rem = 0, busy_run = 0;
  bit   lu_mask = 0, m_tmo = 0;
  logic [7:0] exp_vec;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .ZERO_REG(ZR), .BRANCH_PENALTY(BP), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_timeout(mem_timeout)
`ifdef STALL_PERF_CNT_EN
    , .stall_cnt_clr(stall_cnt_clr), .stall_cycles(stall_cycles)
`endif
  );

  function automatic logic [7:0] obs();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_timeout};
  endfunction

  task automatic model_reset();
    flush_rem = 0; busy_run = 0; lu_mask = 0; m_tmo = 0;
`ifdef STALL_PERF_CNT_EN
    m_perf = 0;
`endif
  endtask

  // Drive one cycle's inputs after the falling edge, compute expected outputs, advance model.
  task automatic cycle(input bit b, input bit br, input bit mr, input logic [RW-1:0] rd,
                       input logic [RW-1:0] rn, input logic [RW-1:0] rm, input bit urm);
    logic [6:0] c;
    bit h, stall;
    @(negedge clk);
    mem_busy = b; ex_branch_taken = br; ex_mem_read = mr;
    ex_rd = rd; id_rn = rn; id_rm = rm; id_uses_rm = urm;
    #1;
    h = mr && (rd != RW'(ZR)) && (rd == rn || (urm && rd == rm));
    stall = 0;
    exp_vec[0] = m_tmo;
    if (b) begin
      c = V_FREEZE;
      busy_run++;
      if (busy_run > MT) m_tmo = 1;
    end else begin
      busy_run = 0;
      if (flush_rem > 0) begin
        c = V_FLUSH; flush_rem--;
      end else if (br) begin
        c = V_FLUSH; flush_rem = BP - 1;
      end else if (h && !lu_mask) begin
        c = V_STALL; stall = 1;
      end else begin
        c = V_NORMAL;
      end
    end
    lu_mask = stall;
    exp_vec[7:1] = c;
`ifdef STALL_PERF_CNT_EN
    exp_perf = m_perf;
    if (stall_cnt_clr) m_perf = 0;
    else if (!c[6])    m_perf++;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0; ex_branch_taken = 1'b1; mem_busy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs() !== 8'h00)
      begin errors++; $display("FAIL reset_hold got %b exp %b", obs(), 8'h00); end
    model_reset();
    @(negedge clk);
    reset = 1'b1; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    #1;
    checks++;
    if (obs() !== {V_NORMAL, 1'b0})
      begin errors++; $display("FAIL reset_release got %b exp %b", obs(), {V_NORMAL, 1'b0}); end
  endtask

  task automatic test_load_use();
    int stalls;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) cycle(0, 0, 1, 5'd3, 5'd3, 5'd0, 0);
      else       cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      if (!pc_en) stalls++;
      checks++;
      if (obs() !== exp_vec)
        begin errors++; $display("FAIL load_use cyc%0d got %b exp %b", i, obs(), exp_vec); end
    end
    checks++;
    if (stalls != 1) begin errors++; $display("FAIL load_use_len got %0d exp 1", stalls); end
    stalls = 0;
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 5'd31, 5'd31, 5'd31, 1);
      if (!pc_en) stalls++;
    end
    cycle(0, 0, 1, 5'd7, 5'd0, 5'd7, 0);
    if (!pc_en) stalls++;
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL load_use_nohaz got %0d exp 0", stalls); end
    cycle(0, 0, 1, 5'd7, 5'd0, 5'd7, 1);
    checks++;
    if (obs() !== {V_STALL, 1'b0})
      begin errors++; $display("FAIL load_use_rm got %b exp %b", obs(), {V_STALL, 1'b0}); end
    cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic test_branch();
    int fl;
    fl = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, i == 0, 0, 5'd0, 5'd0, 5'd0, 0);
      if (if_id_flush && id_ex_flush && pc_en) fl++;
      checks++;
      if (obs() !== exp_vec || !pc_en)
        begin errors++; $display("FAIL branch cyc%0d got %b exp %b", i, obs(), exp_vec); end
    end
    checks++;
    if (fl != BP) begin errors++; $display("FAIL branch_len got %0d exp %0d", fl, BP); end
  endtask

  task automatic test_mem_wait();
    int fr;
    fr = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(i < 4, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      if (obs() == 8'h00) fr++;
      checks++;
      if (obs() !== exp_vec)
        begin errors++; $display("FAIL mem_wait cyc%0d got %b exp %b", i, obs(), exp_vec); end
    end
    checks++;
    if (fr != 4) begin errors++; $display("FAIL mem_wait_len got %0d exp 4", fr); end
  endtask

  task automatic test_collision();
    int fr, fl;
    fr = 0; fl = 0;
    // Branch held in EX across the freeze, then released.
    for (int i = 0; i < 7; i++) begin
      cycle(i < 3, i < 4, 0, 5'd0, 5'd0, 5'd0, 0);
      if (obs() == 8'h00) fr++;
      if (if_id_flush) fl++;
      checks++;
      if (obs() !== exp_vec)
        begin errors++; $display("FAIL collide_a cyc%0d got %b exp %b", i, obs(), exp_vec); end
    end
    checks++;
    if (fr != 3 || fl != BP)
      begin errors++; $display("FAIL collide_a_len got %0d/%0d exp 3/%0d", fr, fl, BP); end
    fr = 0; fl = 0;
    // Busy arrives while the post-branch flush is still owed.
    for (int i = 0; i < 6; i++) begin
      cycle(i == 1 || i == 2, i == 0 || i == 1, 0, 5'd0, 5'd0, 5'd0, 0);
      if (obs() == 8'h00) fr++;
      if (if_id_flush) fl++;
      checks++;
      if (obs() !== exp_vec)
        begin errors++; $display("FAIL collide_b cyc%0d got %b exp %b", i, obs(), exp_vec); end
    end
    checks++;
    if (fr != 2 || fl != BP)
      begin errors++; $display("FAIL collide_b_len got %0d/%0d exp 2/%0d", fr, fl, BP); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < MT + 3; i++) begin
      cycle(i < MT, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      checks++;
      if (obs() !== exp_vec)
        begin errors++; $display("FAIL timeout_15 cyc%0d got %b exp %b", i, obs(), exp_vec); end
    end
    checks++;
    if (mem_timeout !== 1'b0)
      begin errors++; $display("FAIL timeout_15_flag got %b exp 0", mem_timeout); end
    for (int i = 0; i < MT + 4; i++) begin
      cycle(i < MT + 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      checks++;
      if (obs() !== exp_vec)
        begin errors++; $display("FAIL timeout_16 cyc%0d got %b exp %b", i, obs(), exp_vec); end
    end
    checks++;
    if (mem_timeout !== 1'b1)
      begin errors++; $display("FAIL timeout_16_flag got %b exp 1", mem_timeout); end
  endtask

  task automatic test_async_reset();
    cycle(0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== 8'h00)
      begin errors++; $display("FAIL async_reset got %b exp %b", obs(), 8'h00); end
    model_reset();
    @(negedge clk);
    reset = 1'b1; ex_branch_taken = 1'b0; mem_busy = 1'b0; ex_mem_read = 1'b0;
    #1;
    checks++;
    if (obs() !== {V_NORMAL, 1'b0})
      begin errors++; $display("FAIL async_release got %b exp %b", obs(), {V_NORMAL, 1'b0}); end
  endtask

  function automatic logic [RW-1:0] rnd_reg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? RW'(ZR) : RW'(v);
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            rnd_reg(), rnd_reg(), rnd_reg(), $urandom_range(0, 1) == 1);
      checks++;
      if (obs() !== exp_vec)
        begin errors++; $display("FAIL random cyc%0d got %b exp %b", i, obs(), exp_vec); end
    end
  endtask

`ifdef STALL_PERF_CNT_EN
  task automatic test_perf();
    stall_cnt_clr = 1'b1;
    cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    stall_cnt_clr = 1'b0;
    cycle(0, 0, 1, 5'd3, 5'd3, 5'd0, 0);
    cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    checks++;
    if (stall_cycles !== 32'd5 || exp_perf != 5)
      begin errors++; $display("FAIL perf_count got %0d exp 5", stall_cycles); end
    stall_cnt_clr = 1'b1;
    cycle(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    stall_cnt_clr = 1'b0;
    cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    checks++;
    if (stall_cycles !== 32'd0)
      begin errors++; $display("FAIL perf_clear got %0d exp 0", stall_cycles); end
    for (int i = 0; i < 40; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 1'b1,
            rnd_reg(), rnd_reg(), rnd_reg(), 1'b1);
      checks++;
      if (stall_cycles !== exp_perf)
        begin errors++; $display("FAIL perf_rand cyc%0d got %0d exp %0d", i, stall_cycles, exp_perf); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_collision();
    test_timeout();
    test_async_reset();
    test_random();
`ifdef STALL_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
